// File: rtl/mem_line_arbiter.sv
// rtl/mem_line_arbiter.sv - two-client line-memory arbiter for I/D cache refill and write-back
module mem_line_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [LINE_W-1:0] i_mem_wdata,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, GAP} state_t;

  state_t            state, state_nxt;
  logic              last_d, last_d_nxt;
  logic              mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [LINE_W-1:0] mem_wdata_nxt;

  logic              i_req, d_req, grant_d;
  logic              sel_read, sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  assign i_req = i_mem_read | i_mem_write;
  assign d_req = d_mem_read | d_mem_write;

  // On a tie, round-robin favours whoever was not served last; otherwise D always wins.
  assign grant_d = d_req & (~i_req | ~RR_EN | ~last_d);

  assign sel_read  = grant_d ? d_mem_read  : i_mem_read;
  assign sel_write = grant_d ? d_mem_write : i_mem_write;
  assign sel_addr  = grant_d ? d_mem_addr  : i_mem_addr;
  assign sel_wdata = grant_d ? d_mem_wdata : i_mem_wdata;

  always_comb begin
    state_nxt     = state;
    last_d_nxt    = last_d;
    mem_read_nxt  = mem_read;
    mem_write_nxt = mem_write;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (i_req | d_req) begin
          state_nxt     = grant_d ? BUSY_D : BUSY_I;
          last_d_nxt    = grant_d;
          // A combined read+write is issued as the write-back only; the refill comes later.
          mem_write_nxt = sel_write;
          mem_read_nxt  = sel_read & ~sel_write;
          mem_addr_nxt  = sel_addr;
          mem_wdata_nxt = sel_wdata;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_nxt     = GAP;
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      last_d    <= last_d_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
    end
  end

  assign i_mem_ready = mem_ready & (state == BUSY_I);
  assign d_mem_ready = mem_ready & (state == BUSY_D);
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb/tb_mem_line_arbiter.sv - bench for mem_line_arbiter: index 0 round-robin, index 1 fixed priority
module tb_mem_line_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam logic [LW-1:0] I_PAT = {16{8'h11}};
  localparam logic [LW-1:0] D_PAT = {16{8'hDD}};

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]         i_rd, i_wr, d_rd, d_wr, i_rdy, d_rdy, m_rd, m_wr, m_rdy;
  logic [1:0][AW-1:0] i_ad, d_ad, m_ad;
  logic [1:0][LW-1:0] i_wd, d_wd, i_rdat, d_rdat, m_wd, m_rdat;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          k;
    bit          ir, iw, dr, dw;
    logic [AW-1:0] ia, da;
    bit          e_rd, e_wr;
    logic [AW-1:0] e_ad;
    bit          e_d, e_gnt;
  } vec_t;
  vec_t tbl[8];

  // reference model state, one per instance
  int            own[2];     // 0 none, 1 I, 2 D
  bit            gap[2], lastd[2];
  logic          e_rd[2], e_wr[2];
  logic [AW-1:0] e_ad[2];
  logic [LW-1:0] e_wd[2];
  bit            i_seen[2], d_seen[2], mact[2];
  int            mcnt[2];

  always #5 clk = ~clk;

  mem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_rd[0]), .i_mem_write(i_wr[0]), .i_mem_addr(i_ad[0]), .i_mem_wdata(i_wd[0]),
    .i_mem_rdata(i_rdat[0]), .i_mem_ready(i_rdy[0]),
    .d_mem_read(d_rd[0]), .d_mem_write(d_wr[0]), .d_mem_addr(d_ad[0]), .d_mem_wdata(d_wd[0]),
    .d_mem_rdata(d_rdat[0]), .d_mem_ready(d_rdy[0]),
    .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_addr(m_ad[0]), .mem_wdata(m_wd[0]),
    .mem_rdata(m_rdat[0]), .mem_ready(m_rdy[0])
  );

  mem_line_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b0)) u_fx (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_rd[1]), .i_mem_write(i_wr[1]), .i_mem_addr(i_ad[1]), .i_mem_wdata(i_wd[1]),
    .i_mem_rdata(i_rdat[1]), .i_mem_ready(i_rdy[1]),
    .d_mem_read(d_rd[1]), .d_mem_write(d_wr[1]), .d_mem_addr(d_ad[1]), .d_mem_wdata(d_wd[1]),
    .d_mem_rdata(d_rdat[1]), .d_mem_ready(d_rdy[1]),
    .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_addr(m_ad[1]), .mem_wdata(m_wd[1]),
    .mem_rdata(m_rdat[1]), .mem_ready(m_rdy[1])
  );

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    i_rd = '0; i_wr = '0; d_rd = '0; d_wr = '0; m_rdy = '0;
    i_ad = '0; d_ad = '0; i_wd = '0; d_wd = '0; m_rdat = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic serve(input bit k, input int lat, input bit exp_d, input bit exp_wr,
                       input logic [AW-1:0] exp_ad, input bit keep, input logic [LW-1:0] rdat);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 12) begin
      @(negedge clk);
      if (m_rd[k] | m_wr[k]) got = 1'b1;
      else n++;
    end
    chk("serve request issued", LW'(got), LW'(1));
    if (!got) return;
    chk("serve grant latency", LW'(n), LW'(1));
    chk("serve mem_write", LW'(m_wr[k]), LW'(exp_wr));
    chk("serve mem_read", LW'(m_rd[k]), LW'(!exp_wr));
    chk("serve mem_addr", LW'(m_ad[k]), LW'(exp_ad));
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk("serve early i_ready", LW'(i_rdy[k]), LW'(0));
      chk("serve early d_ready", LW'(d_rdy[k]), LW'(0));
      chk("serve addr hold", LW'(m_ad[k]), LW'(exp_ad));
    end
    @(posedge clk); #1;
    m_rdy[k] = 1'b1;
    m_rdat[k] = rdat;
    @(negedge clk);
    chk("serve i_ready", LW'(i_rdy[k]), LW'(!exp_d));
    chk("serve d_ready", LW'(d_rdy[k]), LW'(exp_d));
    chk("serve i_rdata", i_rdat[k], rdat);
    chk("serve d_rdata", d_rdat[k], rdat);
    @(posedge clk); #1;
    m_rdy[k] = 1'b0;
    if (!keep) begin
      if (exp_d) begin d_rd[k] = 1'b0; d_wr[k] = 1'b0; end
      else begin i_rd[k] = 1'b0; i_wr[k] = 1'b0; end
    end
    @(negedge clk);
    chk("serve read cleared", LW'(m_rd[k]), LW'(0));
    chk("serve write cleared", LW'(m_wr[k]), LW'(0));
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      own[j] = 0; gap[j] = 0; lastd[j] = 0;
      e_rd[j] = 0; e_wr[j] = 0; e_ad[j] = '0; e_wd[j] = '0;
      i_seen[j] = 0; d_seen[j] = 0; mact[j] = 0; mcnt[j] = 0;
    end
  endtask

  task automatic model_check(input bit k);
    chk($sformatf("rand%0d mem_read", k), LW'(m_rd[k]), LW'(e_rd[k]));
    chk($sformatf("rand%0d mem_write", k), LW'(m_wr[k]), LW'(e_wr[k]));
    chk($sformatf("rand%0d mem_addr", k), LW'(m_ad[k]), LW'(e_ad[k]));
    chk($sformatf("rand%0d mem_wdata", k), m_wd[k], e_wd[k]);
    chk($sformatf("rand%0d i_ready", k), LW'(i_rdy[k]), LW'(own[k] == 1 && m_rdy[k]));
    chk($sformatf("rand%0d d_ready", k), LW'(d_rdy[k]), LW'(own[k] == 2 && m_rdy[k]));
    chk($sformatf("rand%0d i_rdata", k), i_rdat[k], m_rdat[k]);
    chk($sformatf("rand%0d d_rdata", k), d_rdat[k], m_rdat[k]);
  endtask

  task automatic model_step(input bit k);
    bit ireq, dreq, pick_d;
    ireq = i_rd[k] | i_wr[k];
    dreq = d_rd[k] | d_wr[k];
    i_seen[k] = (own[k] == 1) && m_rdy[k];
    d_seen[k] = (own[k] == 2) && m_rdy[k];
    if (own[k] != 0) begin
      if (m_rdy[k]) begin
        own[k] = 0; gap[k] = 1; e_rd[k] = 0; e_wr[k] = 0;
      end
    end else if (gap[k]) begin
      gap[k] = 0;
    end else if (ireq || dreq) begin
      if (ireq && dreq) pick_d = (k == 1'b0) ? !lastd[k] : 1'b1;
      else pick_d = dreq;
      lastd[k] = pick_d;
      own[k] = pick_d ? 2 : 1;
      e_wr[k] = pick_d ? d_wr[k] : i_wr[k];
      e_rd[k] = (pick_d ? d_rd[k] : i_rd[k]) && !e_wr[k];
      e_ad[k] = pick_d ? d_ad[k] : i_ad[k];
      e_wd[k] = pick_d ? d_wd[k] : i_wd[k];
    end
  endtask

  task automatic drive_random(input bit k);
    int op;
    if (m_rdy[k]) begin
      m_rdy[k] = 1'b0;
      mact[k] = 1'b0;
    end else if (mact[k]) begin
      mcnt[k]--;
      if (mcnt[k] <= 0) begin m_rdy[k] = 1'b1; m_rdat[k] = {4{$urandom()}}; end
    end else if (m_rd[k] | m_wr[k]) begin
      mact[k] = 1'b1;
      mcnt[k] = $urandom_range(0, 4);
      if (mcnt[k] == 0) begin m_rdy[k] = 1'b1; m_rdat[k] = {4{$urandom()}}; end
    end else if ($urandom_range(0, 9) == 0) begin
      m_rdy[k] = 1'b1;
      m_rdat[k] = {4{$urandom()}};
    end
    if (i_seen[k]) begin
      i_rd[k] = 1'b0; i_wr[k] = 1'b0; i_seen[k] = 1'b0;
    end else if (!(i_rd[k] | i_wr[k]) && $urandom_range(0, 2) == 0) begin
      op = $urandom_range(0, 3);
      i_rd[k] = (op != 2); i_wr[k] = (op >= 2);
      i_ad[k] = AW'($urandom()); i_wd[k] = {4{$urandom()}};
    end
    if (d_seen[k]) begin
      d_rd[k] = 1'b0; d_wr[k] = 1'b0; d_seen[k] = 1'b0;
    end else if (!(d_rd[k] | d_wr[k]) && $urandom_range(0, 2) == 0) begin
      op = $urandom_range(0, 3);
      d_rd[k] = (op != 2); d_wr[k] = (op >= 2);
      d_ad[k] = AW'($urandom()); d_wd[k] = {4{$urandom()}};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b0, 1, 0, 0, 0, 28'h010, 28'h000, 1, 0, 28'h010, 0, 1};
    tbl[1] = '{1'b0, 0, 0, 0, 1, 28'h000, 28'h200, 0, 1, 28'h200, 1, 1};
    tbl[2] = '{1'b0, 1, 0, 0, 1, 28'h100, 28'h200, 0, 1, 28'h200, 1, 1};
    tbl[3] = '{1'b0, 0, 0, 1, 1, 28'h000, 28'h300, 0, 1, 28'h300, 1, 1};
    tbl[4] = '{1'b1, 1, 0, 1, 0, 28'h140, 28'h240, 1, 0, 28'h240, 1, 1};
    tbl[5] = '{1'b1, 0, 1, 0, 0, 28'h040, 28'h000, 0, 1, 28'h040, 0, 1};
    tbl[6] = '{1'b0, 1, 1, 0, 0, 28'h050, 28'h000, 0, 1, 28'h050, 0, 1};
    tbl[7] = '{1'b1, 0, 0, 0, 0, 28'h060, 28'h070, 0, 0, 28'h000, 0, 0};

    reset_all();
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk("reset mem_read", LW'(m_rd[j]), LW'(0));
      chk("reset mem_write", LW'(m_wr[j]), LW'(0));
      chk("reset mem_addr", LW'(m_ad[j]), LW'(0));
      chk("reset mem_wdata", m_wd[j], LW'(0));
      chk("reset i_ready", LW'(i_rdy[j]), LW'(0));
      chk("reset d_ready", LW'(d_rdy[j]), LW'(0));
    end

    for (int v = 0; v < 8; v++) begin
      bit k;
      logic [LW-1:0] rpat;
      reset_all();
      k = tbl[v].k;
      rpat = {4{32'hC0DE_0000 + 32'(v)}};
      i_rd[k] = tbl[v].ir; i_wr[k] = tbl[v].iw; i_ad[k] = tbl[v].ia; i_wd[k] = I_PAT;
      d_rd[k] = tbl[v].dr; d_wr[k] = tbl[v].dw; d_ad[k] = tbl[v].da; d_wd[k] = D_PAT;
      @(negedge clk);
      chk($sformatf("vec%0d mem_read before edge", v), LW'(m_rd[k]), LW'(0));
      @(negedge clk);
      chk($sformatf("vec%0d mem_read", v), LW'(m_rd[k]), LW'(tbl[v].e_rd));
      chk($sformatf("vec%0d mem_write", v), LW'(m_wr[k]), LW'(tbl[v].e_wr));
      chk($sformatf("vec%0d mem_addr", v), LW'(m_ad[k]), LW'(tbl[v].e_ad));
      chk($sformatf("vec%0d mem_wdata", v), m_wd[k],
          tbl[v].e_gnt ? (tbl[v].e_d ? D_PAT : I_PAT) : LW'(0));
      @(posedge clk); #1;
      m_rdy[k] = 1'b1;
      m_rdat[k] = rpat;
      @(negedge clk);
      chk($sformatf("vec%0d i_ready", v), LW'(i_rdy[k]), LW'(tbl[v].e_gnt && !tbl[v].e_d));
      chk($sformatf("vec%0d d_ready", v), LW'(d_rdy[k]), LW'(tbl[v].e_gnt && tbl[v].e_d));
      chk($sformatf("vec%0d i_rdata", v), i_rdat[k], rpat);
      @(posedge clk); #1;
      m_rdy[k] = 1'b0;
      i_rd[k] = 0; i_wr[k] = 0; d_rd[k] = 0; d_wr[k] = 0;
      @(negedge clk);
      chk($sformatf("vec%0d read after ready", v), LW'(m_rd[k]), LW'(0));
      chk($sformatf("vec%0d write after ready", v), LW'(m_wr[k]), LW'(0));
    end

    // single I read, memory latency 5
    reset_all();
    i_rd[0] = 1'b1; i_ad[0] = 28'h0000010;
    serve(1'b0, 5, 1'b0, 1'b0, 28'h0000010, 1'b0, {16{8'hA5}});

    // round-robin alternation with both clients holding their requests
    reset_all();
    i_rd[0] = 1'b1; i_ad[0] = 28'h100;
    d_wr[0] = 1'b1; d_ad[0] = 28'h200;
    serve(1'b0, 2, 1'b1, 1'b1, 28'h200, 1'b1, {4{32'h1}});
    serve(1'b0, 2, 1'b0, 1'b0, 28'h100, 1'b1, {4{32'h2}});
    serve(1'b0, 3, 1'b1, 1'b1, 28'h200, 1'b1, {4{32'h3}});
    serve(1'b0, 1, 1'b0, 1'b0, 28'h100, 1'b0, {4{32'h4}});

    // fixed priority starves I until D lets go
    reset_all();
    i_rd[1] = 1'b1; i_ad[1] = 28'h100;
    d_rd[1] = 1'b1; d_ad[1] = 28'h200;
    serve(1'b1, 1, 1'b1, 1'b0, 28'h200, 1'b1, {4{32'h5}});
    serve(1'b1, 2, 1'b1, 1'b0, 28'h200, 1'b1, {4{32'h6}});
    serve(1'b1, 1, 1'b1, 1'b0, 28'h200, 1'b0, {4{32'h7}});
    serve(1'b1, 2, 1'b0, 1'b0, 28'h100, 1'b0, {4{32'h8}});

    // D write-back then refill
    reset_all();
    d_rd[0] = 1'b1; d_wr[0] = 1'b1; d_ad[0] = 28'h300;
    serve(1'b0, 2, 1'b1, 1'b1, 28'h300, 1'b1, {4{32'h9}});
    d_wr[0] = 1'b0;
    serve(1'b0, 2, 1'b1, 1'b0, 28'h300, 1'b0, {4{32'hA}});

    // spurious ready in IDLE, then address change during BUSY_D
    reset_all();
    m_rdy[0] = 1'b1;
    @(negedge clk);
    chk("spurious i_ready", LW'(i_rdy[0]), LW'(0));
    chk("spurious d_ready", LW'(d_rdy[0]), LW'(0));
    @(posedge clk); #1;
    m_rdy[0] = 1'b0;
    d_rd[0] = 1'b1; d_ad[0] = 28'h200;
    repeat (2) @(negedge clk);
    chk("busy_d mem_read", LW'(m_rd[0]), LW'(1));
    @(posedge clk); #1;
    d_ad[0] = 28'h3FF; d_rd[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("busy_d addr held", LW'(m_ad[0]), LW'(28'h200));
      chk("busy_d read held", LW'(m_rd[0]), LW'(1));
    end
    @(posedge clk); #1;
    m_rdy[0] = 1'b1;
    @(negedge clk);
    chk("busy_d completion", LW'(d_rdy[0]), LW'(1));
    @(posedge clk); #1;
    m_rdy[0] = 1'b0;
    @(negedge clk);
    chk("busy_d read dropped", LW'(m_rd[0]), LW'(0));
    chk("busy_d addr kept", LW'(m_ad[0]), LW'(28'h200));

    // asynchronous reset in the middle of BUSY_D
    reset_all();
    d_rd[0] = 1'b1; d_ad[0] = 28'h200;
    repeat (2) @(negedge clk);
    chk("pre-reset mem_read", LW'(m_rd[0]), LW'(1));
    @(posedge clk); #3;
    m_rdy[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async reset mem_read", LW'(m_rd[0]), LW'(0));
    chk("async reset mem_write", LW'(m_wr[0]), LW'(0));
    chk("async reset d_ready", LW'(d_rdy[0]), LW'(0));
    chk("async reset i_ready", LW'(i_rdy[0]), LW'(0));
    @(posedge clk); #1;
    m_rdy[0] = 1'b0; d_rd[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset mem_read", LW'(m_rd[0]), LW'(0));
    chk("post-reset mem_addr", LW'(m_ad[0]), LW'(0));
    chk("post-reset mem_wdata", m_wd[0], LW'(0));

    // randomized traffic against the reference model
    reset_all();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      drive_random(1'b0);
      drive_random(1'b1);
      @(negedge clk);
      model_check(1'b0);
      model_step(1'b0);
      model_check(1'b1);
      model_step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
